// File: rtl/rc5_rx_decoder_if.sv
// rtl/rc5_rx_decoder_if.sv - IR input and decoded-frame outputs of the RC-5 receiver
interface rc5_rx_decoder_if;
    logic       ir_in;
    logic       frame_valid;
    logic       toggle;
    logic [4:0] address;
    logic [6:0] command;
    logic       rx_error;
    logic       busy;

    modport master (
        input  ir_in,
        output frame_valid, toggle, address, command, rx_error, busy
    );

    modport slave (
        output ir_in,
        input  frame_valid, toggle, address, command, rx_error, busy
    );
endinterface

// File: rtl/rc5_rx_decoder.sv
// rtl/rc5_rx_decoder.sv - RC-5 Manchester receiver with mid-bit edge resynchronisation
module rc5_rx_decoder #(
    parameter int HALF_BIT = 88900,
    parameter int GAP_CYC  = 177800
) (
    input  logic                clk,
    input  logic                rst,
    rc5_rx_decoder_if.master    bus
);
    localparam int CW = $clog2(2*HALF_BIT);
    localparam int GW = $clog2(GAP_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(2*HALF_BIT - 1);
    localparam logic [CW-1:0] B_PT     = CW'(HALF_BIT/2);
    localparam logic [CW-1:0] A_PT     = CW'(3*HALF_BIT/2);
    localparam logic [CW-1:0] EARLY    = CW'(2*HALF_BIT - HALF_BIT/4);
    localparam logic [CW-1:0] LATE     = CW'(HALF_BIT/4);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, RECV, GAP} state_t;

    state_t         state, state_n;
    logic           sync1, ir_s, ir_d;
    logic [CW-1:0]  cnt, cnt_n;
    logic [3:0]     b, b_n;
    logic [GW-1:0]  gap, gap_n;
    logic           a_q, a_n;
    logic [12:0]    sh, sh_n;
    logic           fv, fv_n, err, err_n;
    logic           tog;
    logic [4:0]     addr;
    logic [6:0]     cmd;
    logic           ir_edge, ir_rise;

    assign ir_edge = ir_s ^ ir_d;
    assign ir_rise = ir_s & ~ir_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            ir_s  <= 1'b0;
            ir_d  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            b     <= '0;
            gap   <= '0;
            a_q   <= 1'b0;
            sh    <= '0;
            fv    <= 1'b0;
            err   <= 1'b0;
            tog   <= 1'b0;
            addr  <= '0;
            cmd   <= '0;
        end else begin
            sync1 <= bus.ir_in;
            ir_s  <= sync1;
            ir_d  <= ir_s;
            state <= state_n;
            cnt   <= cnt_n;
            b     <= b_n;
            gap   <= gap_n;
            a_q   <= a_n;
            sh    <= sh_n;
            fv    <= fv_n;
            err   <= err_n;
            // sh_n = {S2, T, A4..A0, C5..C0}
            if (fv_n) begin
                tog  <= sh_n[11];
                addr <= sh_n[10:6];
                cmd  <= {~sh_n[12], sh_n[5:0]};
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        b_n     = b;
        gap_n   = '0;
        a_n     = a_q;
        sh_n    = sh;
        fv_n    = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (ir_rise) begin
                    state_n = RECV;
                    cnt_n   = '0;
                    b_n     = '0;
                end
            end
            RECV: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    b_n   = b + 4'd1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
                // During S1 only edges after its B-sample (the S2 mid-bit) may resync.
                if (ir_edge && (b != 4'd0 || cnt > B_PT)) begin
                    if (cnt >= EARLY) begin
                        cnt_n = '0;
                        b_n   = b + 4'd1;
                    end else if (cnt != '0 && cnt <= LATE) begin
                        cnt_n = '0;
                    end
                end
                if (cnt == B_PT) begin
                    if ((b == 4'd0) ? !ir_s : (a_q == ir_s)) begin
                        err_n   = 1'b1;
                        state_n = GAP;
                    end else if (b != 4'd0) begin
                        sh_n = {sh[11:0], ir_s};
                        if (b == 4'd13) begin
                            fv_n    = 1'b1;
                            state_n = GAP;
                        end
                    end
                end
                if (cnt == A_PT)
                    a_n = ir_s;
            end
            GAP: begin
                if (!ir_s) begin
                    if (gap == GAP_LAST)
                        state_n = IDLE;
                    else
                        gap_n = gap + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.frame_valid = fv;
    assign bus.rx_error    = err;
    assign bus.toggle      = tog;
    assign bus.address     = addr;
    assign bus.command     = cmd;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_rc5_rx_decoder.sv
// tb/tb_rc5_rx_decoder.sv - scoreboard bench for rc5_rx_decoder with directed frames
module tb_rc5_rx_decoder;
    localparam int HB  = 16;
    localparam int GAP = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rc5_rx_decoder_if bus();

    rc5_rx_decoder #(.HALF_BIT(HB), .GAP_CYC(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       is_err;
        logic       toggle;
        logic [4:0] address;
        logic [6:0] command;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    logic       last_t = 1'b0;
    logic [4:0] last_a = 5'h00;
    logic [6:0] last_c = 7'h00;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic hold(input logic v, input int n);
        bus.ir_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // bad >= 0 forces that bit to mark for both halves
    task automatic send_frame(input logic [13:0] f, input int hb, input int nbits, input int bad);
        for (int i = 0; i < nbits; i++) begin
            if (i == bad) begin
                hold(1'b1, 2*hb);
            end else begin
                hold(~f[13-i], hb);
                hold(f[13-i], hb);
            end
        end
        bus.ir_in = 1'b0;
    endtask

    task automatic expect_frame(input logic t, input logic [4:0] a, input logic [6:0] c);
        exp_t x;
        x.is_err = 1'b0; x.toggle = t; x.address = a; x.command = c;
        exp_q.push_back(x);
        last_t = t; last_a = a; last_c = c;
    endtask

    task automatic expect_error();
        exp_t x;
        x.is_err = 1'b1; x.toggle = last_t; x.address = last_a; x.command = last_c;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.frame_valid || bus.rx_error)) begin
            check("strobe_exclusive", int'(bus.frame_valid & bus.rx_error), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: frame_valid=%0d rx_error=%0d, expected none at %0t",
                         bus.frame_valid, bus.rx_error, $time);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind_rx_error", int'(bus.rx_error), int'(e.is_err));
                check("toggle", int'(bus.toggle), int'(e.toggle));
                check("address", int'(bus.address), int'(e.address));
                check("command", int'(bus.command), int'(e.command));
            end
        end
    end

    // {S1, S2, T, A4..A0, C5..C0}
    localparam logic [13:0] F1 = {1'b1, 1'b1, 1'b0, 5'h05, 6'h35};
    localparam logic [13:0] F2 = {1'b1, 1'b0, 1'b1, 5'h05, 6'h35};
    localparam logic [13:0] F3 = {1'b1, 1'b1, 1'b1, 5'h1A, 6'h0A};

    initial begin
        bus.ir_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_frame_valid", int'(bus.frame_valid), 0);
        check("reset_rx_error", int'(bus.rx_error), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_address", int'(bus.address), 0);
        check("reset_command", int'(bus.command), 0);
        check("reset_toggle", int'(bus.toggle), 0);
        rst = 1'b0;
        hold(1'b0, 10);

        // nominal frame
        expect_frame(1'b0, 5'h05, 7'h35);
        send_frame(F1, HB, 14, -1);
        hold(1'b0, 60);
        check("idle_after_frame1", int'(bus.busy), 0);

        // Manchester violation on bit 6; outputs keep frame 1
        expect_error();
        send_frame(F1, HB, 14, 6);
        hold(1'b0, 30);
        check("busy_in_gap", int'(bus.busy), 1);
        hold(1'b0, 20);
        check("idle_after_gap", int'(bus.busy), 0);
        check("held_address", int'(bus.address), 5'h05);
        check("held_command", int'(bus.command), 7'h35);

        // S2=0 extends command range, toggle set
        expect_frame(1'b1, 5'h05, 7'h75);
        send_frame(F2, HB, 14, -1);
        hold(1'b0, 60);

        // transmitter clock off by +/-6%
        expect_frame(1'b1, 5'h1A, 7'h0A);
        send_frame(F3, 17, 14, -1);
        hold(1'b0, 60);
        expect_frame(1'b0, 5'h05, 7'h35);
        send_frame(F1, 15, 14, -1);
        hold(1'b0, 60);

        // reset mid-frame
        send_frame(F1, HB, 7, -1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midreset_busy", int'(bus.busy), 0);
        check("midreset_address", int'(bus.address), 0);
        check("midreset_command", int'(bus.command), 0);
        check("midreset_toggle", int'(bus.toggle), 0);
        rst = 1'b0;
        last_t = 1'b0; last_a = 5'h00; last_c = 7'h00;
        hold(1'b0, 20);
        check("postreset_idle", int'(bus.busy), 0);
        expect_frame(1'b1, 5'h05, 7'h75);
        send_frame(F2, HB, 14, -1);
        hold(1'b0, 60);

        // short glitch in IDLE, then a frame after the gap
        expect_error();
        hold(1'b1, 4);
        hold(1'b0, 40);
        expect_frame(1'b0, 5'h05, 7'h35);
        send_frame(F1, HB, 14, -1);

        // stuck mark right after a frame: stays in GAP, no strobes
        hold(1'b1, 100);
        check("stuck_mark_busy_a", int'(bus.busy), 1);
        hold(1'b1, 200);
        check("stuck_mark_busy_b", int'(bus.busy), 1);
        hold(1'b0, 60);
        check("release_idle", int'(bus.busy), 0);

        check("pending_expectations", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
